// File: rtl/tm1638_pkg.sv
// tm1638_pkg: TM1638 command bytes, FSM state encoding and key decode.
// Shared by the key reader and the LED/display writer.
package tm1638_pkg;
  localparam logic [7:0] CMD_READ_KEYS   = 8'h42;
  localparam logic [7:0] CMD_WRITE_AUTO  = 8'h40;
  localparam logic [7:0] CMD_WRITE_FIXED = 8'h44;
  localparam logic [7:0] CMD_DISP_ON     = 8'h88;
  typedef enum logic [2:0] {IDLE, CMD, WAIT, READ, DONE} state_t;
  // LED&KEY wiring: S1-S4 are bit0 of bytes 0-3, S5-S8 are bit4 of bytes 0-3
  function automatic logic [7:0] decode_keys(input logic [31:0] raw);
    logic [7:0] k;
    k = '0;
    for (int i = 0; i < 4; i++) begin
      k[i]   = raw[8*i];
      k[i+4] = raw[8*i+4];
    end
    return k;
  endfunction
endpackage

// File: rtl/tm1638_bit_timer.sv
// tm1638_bit_timer: CLK_DIV half-period counter; a bit is a low phase then a high phase.
module tm1638_bit_timer #(
  parameter int CLK_DIV = 50
) (
  input  logic CLK,
  input  logic rs,
  input  logic run,
  output logic high,
  output logic phase_start_low,
  output logic phase_start_high,
  output logic sample
);
  localparam int CW = $clog2(CLK_DIV);
  logic [CW-1:0] cnt;
  always_ff @(posedge CLK) begin
    if (!rs || !run) begin
      cnt  <= '0;
      high <= 1'b0;
    end else if (cnt == CW'(CLK_DIV - 1)) begin
      cnt  <= '0;
      high <= !high;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
  assign phase_start_low  = run && !high && cnt == '0;
  assign phase_start_high = run && high && cnt == '0;
  assign sample           = run && high && cnt == CW'(CLK_DIV - 1);
endmodule

// File: rtl/tm1638_key_reader.sv
// tm1638_key_reader: reads the 8 LED&KEY keys via the 0x42 key-scan command.
// Optional TM1638_AUTOSCAN_EN: internal start every SCAN_PERIOD cycles, start port ignored.
module tm1638_key_reader
  import tm1638_pkg::*;
#(
  parameter int CLK_DIV     = 50,
  parameter int WAIT_CYC    = 100,
  parameter int SCAN_PERIOD = 500000
) (
  input  logic        CLK,
  input  logic        rs,
  input  logic        start,
  output logic        busy,
  output logic        tm_stb,
  output logic        tm_clk,
  output logic        tm_dio_out,
  output logic        tm_dio_oe,
  input  logic        tm_dio_in,
  output logic [31:0] raw_scan,
  output logic [7:0]  keys,
  output logic        key_valid
);
  localparam int BW   = $clog2(33);
  localparam int CMAX = WAIT_CYC > CLK_DIV ? WAIT_CYC : CLK_DIV;
  localparam int CYW  = $clog2(CMAX);
  state_t state, next;
  logic [BW-1:0] bit_cnt;
  logic [CYW-1:0] cyc;
  logic [31:0] sr;
  logic dio_q, run, high, phase_start_low, phase_start_high, sample, go;
  assign run = state == CMD || state == READ;
  tm1638_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .CLK(CLK),
    .rs(rs),
    .run(run),
    .high(high),
    .phase_start_low(phase_start_low),
    .phase_start_high(phase_start_high),
    .sample(sample)
  );
`ifdef TM1638_AUTOSCAN_EN
  localparam int SW = $clog2(SCAN_PERIOD);
  logic [SW-1:0] scan_cnt;
  logic tick;
  assign tick = scan_cnt == SW'(SCAN_PERIOD - 1);
  // ticks landing outside IDLE are simply lost; the period never shifts
  always_ff @(posedge CLK) begin
    if (!rs) scan_cnt <= '0;
    else scan_cnt <= tick ? '0 : scan_cnt + 1'b1;
  end
  assign go = tick;
`else
  assign go = start;
`endif
  always_ff @(posedge CLK) begin
    if (!rs) state <= IDLE;
    else state <= next;
  end
  always_comb begin
    next = state;
    case (state)
      IDLE:    if (go) next = CMD;
      CMD:     if (sample && bit_cnt == BW'(8)) next = WAIT;
      WAIT:    if (cyc == CYW'(WAIT_CYC - 1)) next = READ;
      READ:    if (sample && bit_cnt == BW'(32)) next = DONE;
      DONE:    if (cyc == CYW'(CLK_DIV - 1)) next = IDLE;
      default: next = IDLE;
    endcase
  end
  // bit_cnt advances at each high-phase start, so it equals the bit index during the low phase
  always_ff @(posedge CLK) begin
    if (!rs) begin
      bit_cnt   <= '0;
      cyc       <= '0;
      sr        <= '0;
      dio_q     <= 1'b1;
      raw_scan  <= '0;
      keys      <= '0;
      key_valid <= 1'b0;
    end else begin
      bit_cnt   <= next != state ? '0 : bit_cnt + BW'(phase_start_high);
      cyc       <= (next == state && (state == WAIT || state == DONE)) ? cyc + 1'b1 : '0;
      dio_q     <= tm_dio_out;
      key_valid <= state == READ && next == DONE;
      if (state == READ && sample) sr <= {tm_dio_in, sr[31:1]};
      if (state == READ && next == DONE) begin
        raw_scan <= {tm_dio_in, sr[31:1]};
        keys     <= decode_keys({tm_dio_in, sr[31:1]});
      end
    end
  end
  always_comb begin
    busy       = state != IDLE;
    tm_stb     = !(state == CMD || state == WAIT || state == READ);
    tm_clk     = run ? high : 1'b1;
    tm_dio_oe  = state == CMD;
    tm_dio_out = state != CMD ? 1'b1 : phase_start_low ? CMD_READ_KEYS[bit_cnt[2:0]] : dio_q;
  end
endmodule

// File: tb/tb_tm1638_key_reader.sv
// tb_tm1638_key_reader: TM1638 DIO model plus table and random key-scan checks.
`timescale 1ns/1ps
module tb_tm1638_key_reader;
  localparam int CLK_DIV  = 4;
  localparam int WAIT_CYC = 8;
  localparam int LAT      = 1 + 80*CLK_DIV + WAIT_CYC;
  logic CLK = 1'b0, rs = 1'b0, start = 1'b0, tm_dio_in = 1'b1;
  logic busy, tm_stb, tm_clk, tm_dio_out, tm_dio_oe, key_valid;
  logic [31:0] raw_scan;
  logic [7:0] keys;
  int checks = 0, failures = 0;
  int cyc = 0, kv_count = 0, stb_rises = 0, stb_hi = 0, min_stb_hi = 1 << 30, rises = 0;
  logic [31:0] word = '0;
  logic [7:0] cmd_seen = '0;
  logic prev_clk = 1'b1, prev_stb = 1'b1;

  tm1638_key_reader #(.CLK_DIV(CLK_DIV), .WAIT_CYC(WAIT_CYC), .SCAN_PERIOD(1000)) dut (
    .CLK(CLK),
    .rs(rs),
    .start(start),
    .busy(busy),
    .tm_stb(tm_stb),
    .tm_clk(tm_clk),
    .tm_dio_out(tm_dio_out),
    .tm_dio_oe(tm_dio_oe),
    .tm_dio_in(tm_dio_in),
    .raw_scan(raw_scan),
    .keys(keys),
    .key_valid(key_valid)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // chip model: latch command bits on rising CLK, present read bit k after the (8+k)th rise
  always @(negedge CLK) begin
    if (key_valid) kv_count++;
    if (tm_stb && !prev_stb) stb_rises++;
    if (tm_stb) begin
      rises = 0;
      tm_dio_in = 1'b1;
      stb_hi++;
    end else begin
      if (prev_stb && stb_hi < min_stb_hi) min_stb_hi = stb_hi;
      stb_hi = 0;
      if (tm_clk && !prev_clk) begin
        if (rises < 8) cmd_seen[rises] = tm_dio_out;
        rises++;
      end
      if (!tm_clk && prev_clk && rises >= 8) tm_dio_in = word[rises-8];
    end
    prev_clk = tm_clk;
    prev_stb = tm_stb;
  end

  function automatic logic [7:0] model_keys(input logic [31:0] s);
    logic [7:0] k;
    k = '0;
    for (int b = 0; b < 8; b++) k[b] = s[(b % 4)*8 + (b / 4)*4];
    return k;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_kv(output int t);
    t = -1;
    for (int i = 0; i < 2*LAT; i++) begin
      @(negedge CLK);
      if (key_valid) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) begin
      checks++;
      failures++;
      $display("FAIL kv_timeout: key_valid absent for %0d cycles", 2*LAT);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 2*LAT) begin
      @(negedge CLK);
      n++;
    end
    if (busy) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout: busy still 1 after %0d cycles", n);
    end
  endtask

  task automatic scan(input logic [31:0] s, input logic [7:0] exp_keys, input string tag);
    int ts, tk;
    word = s;
    cmd_seen = '0;
    @(negedge CLK);
    start = 1'b1;
    ts = cyc;
    @(negedge CLK);
    start = 1'b0;
    chk({tag, "_stb_low"}, 32'(tm_stb), 0);
    chk({tag, "_busy"}, 32'(busy), 1);
    chk({tag, "_oe_cmd"}, 32'(tm_dio_oe), 1);
    repeat (16*CLK_DIV - 1) @(negedge CLK);
    chk({tag, "_oe_last_bit"}, 32'(tm_dio_oe), 1);
    @(negedge CLK);
    chk({tag, "_oe_wait"}, 32'(tm_dio_oe), 0);
    chk({tag, "_clk_wait"}, 32'(tm_clk), 1);
    chk({tag, "_cmd_byte"}, 32'(cmd_seen), 32'h42);
    wait_kv(tk);
    chk({tag, "_latency"}, 32'(tk - ts), LAT);
    chk({tag, "_raw"}, raw_scan, s);
    chk({tag, "_keys"}, 32'(keys), 32'(exp_keys));
    chk({tag, "_stb_done"}, 32'(tm_stb), 1);
    @(negedge CLK);
    chk({tag, "_kv_pulse"}, 32'(key_valid), 0);
    repeat (CLK_DIV - 2) @(negedge CLK);
    chk({tag, "_busy_done"}, 32'(busy), 1);
    @(negedge CLK);
    chk({tag, "_busy_idle"}, 32'(busy), 0);
  endtask

  typedef struct { logic [31:0] scan; logic [7:0] keys; } vec_t;
  vec_t vecs[6];

  initial begin
    int k0, r0, t1, t2, t3;
    logic [31:0] r;
    vecs[0] = '{32'h11001001, 8'hA9};
    vecs[1] = '{32'h00000000, 8'h00};
    vecs[2] = '{32'hFFFFFFFF, 8'hFF};
    vecs[3] = '{32'h10101010, 8'hF0};
    vecs[4] = '{32'h01010101, 8'h0F};
    vecs[5] = '{32'hEEEEEEEE, 8'h00};
    repeat (3) @(negedge CLK);
    chk("rst_stb", 32'(tm_stb), 1);
    chk("rst_clk", 32'(tm_clk), 1);
    chk("rst_dio_out", 32'(tm_dio_out), 1);
    chk("rst_oe", 32'(tm_dio_oe), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_raw", raw_scan, 0);
    chk("rst_keys", 32'(keys), 0);
    chk("rst_kv", 32'(key_valid), 0);
    rs = 1'b1;
    @(negedge CLK);
    for (int i = 0; i < 6; i++) scan(vecs[i].scan, vecs[i].keys, "vec");
    for (int i = 0; i < 6; i++) begin
      r = $urandom;
      scan(r, model_keys(r), "rand");
    end
    // start during READ must be dropped, and STB must stay low across it
    word = 32'hFFFFFFFF;
    k0 = kv_count;
    r0 = stb_rises;
    @(negedge CLK);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (150) @(negedge CLK);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    wait_kv(t1);
    chk("busy_start_raw", raw_scan, 32'hFFFFFFFF);
    wait_idle();
    repeat (400) @(negedge CLK);
    chk("busy_start_kv_count", 32'(kv_count - k0), 1);
    chk("busy_start_stb_rises", 32'(stb_rises - r0), 1);
    // reset in the middle of the command byte
    @(negedge CLK);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (20) @(negedge CLK);
    chk("midcmd_stb", 32'(tm_stb), 0);
    rs = 1'b0;
    @(negedge CLK);
    chk("midrst_stb", 32'(tm_stb), 1);
    chk("midrst_clk", 32'(tm_clk), 1);
    chk("midrst_oe", 32'(tm_dio_oe), 0);
    chk("midrst_keys", 32'(keys), 0);
    chk("midrst_raw", raw_scan, 0);
    chk("midrst_busy", 32'(busy), 0);
    rs = 1'b1;
    r = $urandom;
    scan(r, model_keys(r), "after_rst");
    // start held high: back-to-back scans
    r = $urandom;
    word = r;
    min_stb_hi = 1 << 30;
    @(negedge CLK);
    start = 1'b1;
    wait_kv(t1);
    wait_kv(t2);
    wait_kv(t3);
    start = 1'b0;
    chk("b2b_period1", 32'(t2 - t1), LAT + CLK_DIV);
    chk("b2b_period2", 32'(t3 - t2), LAT + CLK_DIV);
    chk("b2b_raw", raw_scan, r);
    chk("b2b_keys", 32'(keys), 32'(model_keys(r)));
    wait_idle();
    chk("b2b_stb_high_time", 32'(min_stb_hi >= CLK_DIV), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
    $fatal(1);
  end
endmodule
